// File: rtl/gsim_pkg.sv
// Shared sizing, types and FSM states for the Gauss-Seidel matrix-memory read cache.
package gsim_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 256;
    localparam int LINES  = 17;
    localparam int OFF_W  = $clog2(LINES);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] row_t;
    typedef logic [OFF_W-1:0]  off_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // An offset from the window base selects a line only below LINES.
    function automatic logic in_window(input addr_t off);
        return off < addr_t'(LINES);
    endfunction

endpackage

// File: rtl/gsim_mem_cache_if.sv
// Solver-side read port and external-memory port of the matrix cache.
interface gsim_mem_cache_if;
    import gsim_pkg::*;

    logic  i_flush;
    logic  i_rreq;
    addr_t i_addr;
    logic  o_rrdy;
    row_t  o_dout;
    logic  o_dout_vld;
    logic  o_ext_rreq;
    addr_t o_ext_addr;
    logic  i_ext_rrdy;
    row_t  i_ext_dout;
    logic  i_ext_dout_vld;

    modport slave (
        input  i_flush, i_rreq, i_addr, i_ext_rrdy, i_ext_dout, i_ext_dout_vld,
        output o_rrdy, o_dout, o_dout_vld, o_ext_rreq, o_ext_addr
    );

    modport master (
        output i_flush, i_rreq, i_addr, i_ext_rrdy, i_ext_dout, i_ext_dout_vld,
        input  o_rrdy, o_dout, o_dout_vld, o_ext_rreq, o_ext_addr
    );

endinterface

// File: rtl/gsim_line_ram.sv
// Line storage for the matrix window: one synchronous write port, one asynchronous read port.
// Only present when GSIM_MEM_CACHE_EN is defined.
`ifdef GSIM_MEM_CACHE_EN
module gsim_line_ram
    import gsim_pkg::*;
(
    input  logic i_clk,
    input  logic we,
    input  off_t waddr,
    input  row_t wdata,
    input  off_t raddr,
    output row_t rdata
);

    row_t mem_r [LINES];

    // Lines are written only by completed fills; contents need no reset since valid bits gate use.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule
`endif

// File: rtl/gsim_mem_cache.sv
// Matrix-row read cache between the Gauss-Seidel solver and external matrix memory.
// Caching is built only with GSIM_MEM_CACHE_EN defined; otherwise every read goes external.
module gsim_mem_cache
    import gsim_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    gsim_mem_cache_if.slave bus
);

    state_t state_r;
    addr_t  pend_addr_r;
    row_t   dout_r;
    logic   dout_vld_r;
    logic   ext_rreq_r;
    logic   accept_s;
    logic   fill_s;
    logic   hit_s;
    row_t   rd_data_s;

    assign accept_s = bus.i_rreq && (state_r == S_IDLE);
    assign fill_s   = bus.i_ext_dout_vld && (state_r == S_WAIT);

`ifdef GSIM_MEM_CACHE_EN
    addr_t                 base_r;
    logic [LINES-1:0]      valid_r;
    logic [LINES-1:0]      valid_nxt_s;
    logic [LINES-1:0]      fill_mask_s;
    logic [(2**OFF_W)-1:0] valid_pad_s;
    off_t                  pend_off_r;
    addr_t                 off_s;
    logic                  in_win_s;
    off_t                  rd_off_s;
    logic                  clr_all_s;

    assign off_s       = bus.i_addr - base_r;
    assign in_win_s    = in_window(off_s);
    assign rd_off_s    = in_win_s ? off_s[OFF_W-1:0] : {OFF_W{1'b0}};
    assign valid_pad_s = {{((2**OFF_W)-LINES){1'b0}}, valid_r};
    // A flush in the accept cycle must not serve stale data, so it forces the miss path.
    assign hit_s       = in_win_s && valid_pad_s[rd_off_s] && !bus.i_flush;
    assign clr_all_s   = accept_s && !hit_s && !in_win_s;

    // Flush and window moves wipe all lines, but a completing fill still lands its own bit.
    always_comb begin
        fill_mask_s              = {LINES{1'b0}};
        fill_mask_s[pend_off_r]  = fill_s;
        valid_nxt_s              = ((bus.i_flush || clr_all_s) ? {LINES{1'b0}} : valid_r) | fill_mask_s;
    end

    // Window base, valid bits and the line offset of the outstanding fill.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            base_r     <= {ADDR_W{1'b0}};
            valid_r    <= {LINES{1'b0}};
            pend_off_r <= {OFF_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            if (clr_all_s) begin
                base_r     <= bus.i_addr;
                pend_off_r <= {OFF_W{1'b0}};
            end else if (accept_s && !hit_s) begin
                pend_off_r <= rd_off_s;
            end
        end
    end

    gsim_line_ram u_line_ram (
        .i_clk (i_clk),
        .we    (fill_s),
        .waddr (pend_off_r),
        .wdata (bus.i_ext_dout),
        .raddr (rd_off_s),
        .rdata (rd_data_s)
    );
`else
    logic unused_s;

    assign unused_s  = bus.i_flush;
    assign hit_s     = 1'b0;
    assign rd_data_s = {DATA_W{1'b0}};
`endif

    // Request FSM: one outstanding external read, registered response and external request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            pend_addr_r <= {ADDR_W{1'b0}};
            dout_r      <= {DATA_W{1'b0}};
            dout_vld_r  <= 1'b0;
            ext_rreq_r  <= 1'b0;
        end else begin
            dout_vld_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s && hit_s) begin
                        dout_r     <= rd_data_s;
                        dout_vld_r <= 1'b1;
                    end else if (accept_s) begin
                        pend_addr_r <= bus.i_addr;
                        ext_rreq_r  <= 1'b1;
                        state_r     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.i_ext_rrdy) begin
                        ext_rreq_r <= 1'b0;
                        state_r    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fill_s) begin
                        dout_r     <= bus.i_ext_dout;
                        dout_vld_r <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    ext_rreq_r <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rrdy     = (state_r == S_IDLE);
    assign bus.o_dout     = dout_r;
    assign bus.o_dout_vld = dout_vld_r;
    assign bus.o_ext_rreq = ext_rreq_r;
    assign bus.o_ext_addr = pend_addr_r;

endmodule

// File: tb/tb_gsim_mem_cache.sv
// Directed scoreboard bench for gsim_mem_cache; cache scenarios run when GSIM_MEM_CACHE_EN is defined.
module tb_gsim_mem_cache;
    import gsim_pkg::*;

    typedef struct {
        row_t   data;
        longint t;
    } exp_t;

    logic   i_clk;
    logic   i_reset;
    int     total;
    int     bad;
    int     ext_req_cycles;
    exp_t   q[$];

    gsim_mem_cache_if bus ();

    gsim_mem_cache dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic row_t mem_row(input addr_t a);
        row_t r;
        for (int i = 0; i < 16; i++) begin
            r[16*i +: 16] = {6'd0, a} ^ (16'(i) << 10) ^ 16'hC000;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT presents o_dout_vld.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (bus.o_ext_rreq === 1'b1) ext_req_cycles++;
            if (bus.o_dout_vld !== 1'b0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_vld: got vld=%b dout=%0h want no response", bus.o_dout_vld, bus.o_dout);
                end else begin
                    e = q.pop_front();
                    chk("dout", 256'(bus.o_dout), 256'(e.data));
                    chk("vld_time", 256'($time), 256'(e.t));
                end
            end
        end
    end

    task automatic do_read(input addr_t a, input bit miss, input int k, input int lat,
                           input bit flush, input bit hold);
        int   n0;
        exp_t e;
        @(negedge i_clk);
        n0 = ext_req_cycles;
        chk("rrdy_idle", 256'(bus.o_rrdy), 256'(1));
        bus.i_rreq  = 1'b1;
        bus.i_addr  = a;
        bus.i_flush = flush;
        @(posedge i_clk);
        if (!miss) begin
            e.data = mem_row(a);
            e.t    = $time + 5;
            q.push_back(e);
        end
        @(negedge i_clk);
        bus.i_flush = 1'b0;
        if (hold) bus.i_addr = a + 10'd100;
        else bus.i_rreq = 1'b0;
        if (miss) begin
            chk("ext_rreq", 256'(bus.o_ext_rreq), 256'(1));
            chk("ext_addr", 256'(bus.o_ext_addr), 256'(a));
            chk("rrdy_busy", 256'(bus.o_rrdy), 256'(0));
            if (k > 0) begin
                bus.i_ext_dout     = ~mem_row(a);
                bus.i_ext_dout_vld = 1'b1;
            end
            for (int i = 0; i < k; i++) begin
                @(negedge i_clk);
                bus.i_ext_dout_vld = 1'b0;
            end
            bus.i_ext_rrdy = 1'b1;
            @(negedge i_clk);
            bus.i_ext_rrdy = 1'b0;
            chk("ext_rreq_drop", 256'(bus.o_ext_rreq), 256'(0));
            chk("ext_addr_held", 256'(bus.o_ext_addr), 256'(a));
            repeat (lat - 1) @(negedge i_clk);
            bus.i_ext_dout     = mem_row(a);
            bus.i_ext_dout_vld = 1'b1;
            bus.i_rreq         = 1'b0;
            @(posedge i_clk);
            e.data = mem_row(a);
            e.t    = $time + 5;
            q.push_back(e);
            @(negedge i_clk);
            bus.i_ext_dout_vld = 1'b0;
            bus.i_ext_dout     = {DATA_W{1'b0}};
            chk("ext_req_cycles", 256'(ext_req_cycles - n0), 256'(k + 1));
        end else begin
            chk("hit_no_ext", 256'(ext_req_cycles - n0), 256'(0));
        end
    endtask

    task automatic burst(input addr_t a0, input int n);
        int   n0;
        exp_t e;
        @(negedge i_clk);
        n0 = ext_req_cycles;
        for (int i = 0; i < n; i++) begin
            bus.i_rreq = 1'b1;
            bus.i_addr = a0 + addr_t'(i);
            @(posedge i_clk);
            e.data = mem_row(a0 + addr_t'(i));
            e.t    = $time + 5;
            q.push_back(e);
            @(negedge i_clk);
        end
        bus.i_rreq = 1'b0;
        @(negedge i_clk);
        chk("burst_no_ext", 256'(ext_req_cycles - n0), 256'(0));
        chk("burst_drained", 256'(q.size()), 256'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rrdy", 256'(bus.o_rrdy), 256'(1));
        chk("rst_dout", 256'(bus.o_dout), 256'(0));
        chk("rst_dout_vld", 256'(bus.o_dout_vld), 256'(0));
        chk("rst_ext_rreq", 256'(bus.o_ext_rreq), 256'(0));
        chk("rst_ext_addr", 256'(bus.o_ext_addr), 256'(0));
    endtask

    task automatic do_abort(input addr_t a);
        @(negedge i_clk);
        bus.i_rreq = 1'b1;
        bus.i_addr = a;
        @(negedge i_clk);
        bus.i_rreq = 1'b0;
        chk("abort_ext_rreq", 256'(bus.o_ext_rreq), 256'(1));
        bus.i_ext_rrdy = 1'b1;
        @(negedge i_clk);
        bus.i_ext_rrdy = 1'b0;
        i_reset = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge i_clk);
        i_reset            = 1'b0;
        bus.i_ext_dout     = mem_row(a);
        bus.i_ext_dout_vld = 1'b1;
        @(negedge i_clk);
        bus.i_ext_dout_vld = 1'b0;
        chk("late_data_ignored", 256'(bus.o_dout_vld), 256'(0));
        chk("late_rrdy", 256'(bus.o_rrdy), 256'(1));
    endtask

    initial begin
        addr_t last_a;
        total              = 0;
        bad                = 0;
        ext_req_cycles     = 0;
        i_reset            = 1'b1;
        bus.i_flush        = 1'b0;
        bus.i_rreq         = 1'b0;
        bus.i_addr         = {ADDR_W{1'b0}};
        bus.i_ext_rrdy     = 1'b0;
        bus.i_ext_dout     = {DATA_W{1'b0}};
        bus.i_ext_dout_vld = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_reset_outputs();
        i_reset = 1'b0;

`ifdef GSIM_MEM_CACHE_EN
        do_read(10'd34, 1'b1, 0, 3, 1'b0, 1'b0);
        do_read(10'd35, 1'b1, 1, 2, 1'b0, 1'b1);
        do_read(10'd35, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int a = 36; a <= 50; a++) do_read(addr_t'(a), 1'b1, 0, 1, 1'b0, 1'b0);
        burst(10'd34, 17);
        do_read(10'd51, 1'b1, 0, 2, 1'b0, 1'b0);
        do_read(10'd34, 1'b1, 0, 1, 1'b0, 1'b0);
        do_read(10'd40, 1'b1, 0, 1, 1'b0, 1'b0);
        do_read(10'd40, 1'b0, 0, 0, 1'b0, 1'b0);
        do_read(10'd40, 1'b1, 0, 2, 1'b1, 1'b0);
        do_read(10'd40, 1'b0, 0, 0, 1'b0, 1'b0);
        last_a = 10'd40;
`else
        do_read(10'd5, 1'b1, 0, 3, 1'b0, 1'b0);
        do_read(10'd5, 1'b1, 2, 1, 1'b0, 1'b0);
        do_read(10'd5, 1'b1, 1, 2, 1'b1, 1'b1);
        do_read(10'd34, 1'b1, 0, 1, 1'b0, 1'b0);
        last_a = 10'd34;
`endif
        repeat (3) @(negedge i_clk);
        chk("dout_hold", 256'(bus.o_dout), 256'(mem_row(last_a)));
        bus.i_ext_dout     = mem_row(10'd99);
        bus.i_ext_dout_vld = 1'b1;
        @(negedge i_clk);
        bus.i_ext_dout_vld = 1'b0;
        chk("idle_data_ignored", 256'(bus.o_dout_vld), 256'(0));
        chk("idle_dout_hold", 256'(bus.o_dout), 256'(mem_row(last_a)));

        do_abort(10'd7);
        do_read(10'd40, 1'b1, 0, 1, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        chk("queue_empty", 256'(q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
